// File: rtl/cfu_pkg.sv
// Shared definitions for the pipelined CFU SIMD MAC unit:
// op codes, FSM states and width helpers.
package cfu_pkg;

    localparam logic [6:0] OP_CLEAR  = 7'd1;
    localparam logic [6:0] OP_LOAD   = 7'd2;
    localparam logic [6:0] OP_SETOFF = 7'd3;
    localparam logic [6:0] OP_MAC    = 7'd4;
    localparam logic [6:0] OP_READ   = 7'd5;
    localparam logic [6:0] OP_ADD    = 7'd6;
    localparam logic [6:0] OP_RDCLR  = 7'd7;
    localparam logic [6:0] OP_STATUS = 7'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RESP
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // (in + offset) needs one bit more than the wider operand.
    function automatic int prod_w(input int in_w, input int off_w);
        return ((in_w > off_w) ? in_w : off_w) + 1 + in_w;
    endfunction

    function automatic logic needs_drain(input logic [6:0] op);
        return (op == OP_READ) || (op == OP_ADD) || (op == OP_RDCLR);
    endfunction

endpackage

// File: rtl/cfu_simd_mac_pipe_dot_stage.sv
// Two-stage int8 dot product: offset-adjusted lane products,
// then a registered adder tree. A small tag rides along.
module cfu_dot_stage
    import cfu_pkg::*;
#(
    parameter int LANES = 16,
    parameter int TAG_W = 2
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    input  logic [TAG_W-1:0]                               in_tag,
    input  logic [LANES*8-1:0]                             in_vec,
    input  logic [LANES*8-1:0]                             in_flt,
    input  logic signed [8:0]                              in_off,
    output logic                                           out_valid,
    output logic [TAG_W-1:0]                               out_tag,
    output logic signed [prod_w(8, 9)+clog2(LANES)-1:0]    out_sum,
    output logic                                           busy
);
    localparam int PW = prod_w(8, 9);
    localparam int SW = PW + clog2(LANES);

    logic signed [9:0]    adj [LANES];
    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic signed [SW-1:0] sum_d, sum_q;
    logic                 v1_q, v2_q;
    logic [TAG_W-1:0]     tag1_q, tag2_q;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            adj[l]    = 10'(signed'(in_vec[l*8 +: 8])) + 10'(in_off);
            prod_d[l] = PW'(adj[l]) * PW'(signed'(in_flt[l*8 +: 8]));
        end
        sum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_d = sum_d + SW'(prod_q[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            sum_q  <= '0;
            for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                prod_q <= prod_d;
                tag1_q <= in_tag;
            end
            if (v1_q) begin
                sum_q  <= sum_d;
                tag2_q <= tag1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_tag   = tag2_q;
    assign out_sum   = sum_q;
    assign busy      = v1_q | v2_q;

endmodule

// File: rtl/cfu_simd_mac_pipe.sv
// Pipelined CFU SIMD MAC: command FSM, operand buffers, runtime
// input offset and a bank of wrapping or saturating accumulators.
module cfu_simd_mac_pipe
    import cfu_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int ACC_W      = 32,
    parameter int NUM_ACC    = 4,
    parameter bit SAT        = 1'b0,
    parameter int OFFSET_RST = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);
    localparam int WORDS = LANES / 4;
    localparam int VW    = LANES * 8;
    localparam int SEL_W = (NUM_ACC > 1) ? clog2(NUM_ACC) : 1;
    localparam int SUM_W = prod_w(8, 9) + clog2(LANES);
    localparam logic signed [33:0] ACC_MAX = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;
    localparam logic signed [33:0] ACC_MIN = -(34'sd1 <<< (ACC_W - 1));

    function automatic logic [ACC_W-1:0] acc_add(
        input logic [ACC_W-1:0]  a,
        input logic signed [33:0] v
    );
        logic signed [33:0] s;
        s = 34'(signed'(a)) + v;
        if (SAT && (s > ACC_MAX)) return ACC_MAX[ACC_W-1:0];
        if (SAT && (s < ACC_MIN)) return ACC_MIN[ACC_W-1:0];
        return s[ACC_W-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [31:0]          arg_q, arg_d;
    logic [VW-1:0]        in_q, in_d, flt_q, flt_d;
    logic signed [8:0]    off_q, off_d;
    logic [ACC_W-1:0]     acc_q [NUM_ACC];
    logic [ACC_W-1:0]     acc_d [NUM_ACC];
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;

    logic                 mac_go, ex_go;
    logic [6:0]           ex_op, cmd_op;
    logic [SEL_W-1:0]     ex_sel, cmd_sel, dot_tag;
    logic [31:0]          ex_arg;
    logic                 dot_valid, pipe_busy;
    logic signed [SUM_W-1:0] dot_sum;
    logic signed [ACC_W:0]   mac_ext;

    assign cmd_op    = cmd_payload_function_id[9:3];
    assign cmd_sel   = cmd_payload_inputs_0[SEL_W-1:0] & SEL_W'(NUM_ACC - 1);
    assign mac_ext   = (ACC_W + 1)'(dot_sum);
    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_data_q;

    cfu_dot_stage #(
        .LANES (LANES),
        .TAG_W (SEL_W)
    ) u_dot (
        .clk       (clk),
        .rst_n     (reset_n),
        .in_valid  (mac_go),
        .in_tag    (ex_sel),
        .in_vec    (in_q),
        .in_flt    (flt_q),
        .in_off    (off_q),
        .out_valid (dot_valid),
        .out_tag   (dot_tag),
        .out_sum   (dot_sum),
        .busy      (pipe_busy)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        arg_d      = arg_q;
        in_d       = in_q;
        flt_d      = flt_q;
        off_d      = off_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        mac_go     = 1'b0;
        ex_go      = 1'b0;
        ex_op      = op_q;
        ex_sel     = sel_q;
        ex_arg     = arg_q;

        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                if (needs_drain(cmd_op) && pipe_busy) begin
                    state_d = S_DRAIN;
                    op_d    = cmd_op;
                    sel_d   = cmd_sel;
                    arg_d   = cmd_payload_inputs_1;
                end else begin
                    ex_go   = 1'b1;
                    ex_op   = cmd_op;
                    ex_sel  = cmd_sel;
                    ex_arg  = cmd_payload_inputs_1;
                    state_d = S_RESP;
                end
            end
            S_DRAIN: if (!pipe_busy) begin
                ex_go   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Landing MAC first so a same-cycle CLEAR keeps program order.
        if (dot_valid) begin
            for (int a = 0; a < NUM_ACC; a++) begin
                if (SEL_W'(a) == dot_tag) acc_d[a] = acc_add(acc_q[a], 34'(mac_ext));
            end
        end

        if (ex_go) begin
            rsp_data_d = '0;
            case (ex_op)
                OP_CLEAR: for (int a = 0; a < NUM_ACC; a++) begin
                    if (SEL_W'(a) == ex_sel) acc_d[a] = '0;
                end
                OP_LOAD: for (int w = 0; w < WORDS; w++) begin
                    if (cmd_payload_function_id[2:0] == 3'(w)) begin
                        in_d[w*32 +: 32]  = cmd_payload_inputs_0;
                        flt_d[w*32 +: 32] = cmd_payload_inputs_1;
                    end
                end
                OP_SETOFF: off_d = signed'(cmd_payload_inputs_0[8:0]);
                OP_MAC:    mac_go = 1'b1;
                OP_READ: for (int a = 0; a < NUM_ACC; a++) begin
                    if (SEL_W'(a) == ex_sel) rsp_data_d = 32'(signed'(acc_q[a]));
                end
                OP_ADD: for (int a = 0; a < NUM_ACC; a++) begin
                    if (SEL_W'(a) == ex_sel) acc_d[a] = acc_add(acc_q[a], 34'(signed'(ex_arg)));
                end
                OP_RDCLR: for (int a = 0; a < NUM_ACC; a++) begin
                    if (SEL_W'(a) == ex_sel) begin
                        rsp_data_d = 32'(signed'(acc_q[a]));
                        acc_d[a]   = '0;
                    end
                end
                OP_STATUS: rsp_data_d = {16'(LANES), 8'(NUM_ACC), 7'd0, pipe_busy};
                default: ;
            endcase
        end

        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sel_q       <= '0;
            arg_q       <= '0;
            in_q        <= '0;
            flt_q       <= '0;
            off_q       <= 9'(OFFSET_RST);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int a = 0; a < NUM_ACC; a++) acc_q[a] <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            arg_q       <= arg_d;
            in_q        <= in_d;
            flt_q       <= flt_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: doc/cfu_simd_mac_pipe.md
Name: cfu_simd_mac_pipe

Overview:
- Parametrised, pipelined successor to the team's single-cycle CFU SIMD dot-product unit.
- Sits on the CPU CFU command/response port.
- Adds: programmable lane count, runtime input offset, multiple accumulators, optional saturation, and a registered MAC pipeline with hazard stalls.
- Serves int8 conv/FC inner loops (TFLite-style, input offset + int8 filter).

Parameters:
- LANES, 16, int8 lanes per dot product; multiple of 4, 4..32.
- ACC_W, 32, accumulator width in bits; 18..32.
- NUM_ACC, 4, number of independent accumulators; power of 2, 1..8.
- SAT, 0, 1 = accumulators saturate at signed ACC_W limits; 0 = wrap modulo 2^ACC_W.
- OFFSET_RST, 128, reset value of the input-offset register (signed 9-bit).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_payload_function_id  in  10  [9:3] op, [2:0] word index/subfield.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_payload_outputs_0  out  32  response data.

Behaviour:
- Reset (async, reset_n low): rsp_valid=0, rsp_payload_outputs_0=0, all accumulators=0, input/filter buffers=0, offset=OFFSET_RST, pipeline valids=0, state=IDLE. Assertion mid-operation discards any in-flight MAC and pending response.
- FSM states: IDLE, DRAIN, RESP. cmd_ready = (state==IDLE).
- IDLE, on accept: ops READ, ADD, RDCLR go to DRAIN if the MAC pipe is non-empty, else execute that cycle and go to RESP. All other ops execute and go to RESP.
- DRAIN: wait until both pipe valids are 0, execute the held op, then go to RESP.
- RESP: rsp_valid=1 and data stable until rsp_ready, then IDLE. Minimum 2 cycles per command.
- sel = inputs_0[log2(NUM_ACC)-1:0]. For NUM_ACC=1, sel is ignored.
- Ops (response = 0 unless stated):
  - 1 CLEAR: acc[sel]=0.
  - 2 LOAD: input word[fid[2:0]]=inputs_0; filter word[fid[2:0]]=inputs_1. Index >= LANES/4 is ignored.
  - 3 SETOFF: offset=inputs_0[8:0] (signed).
  - 4 MAC: push (buffers, offset, sel) into the pipe.
  - 5 READ: response = acc[sel], sign-extended to 32.
  - 6 ADD: acc[sel] += inputs_1 (bias), truncated/saturated to ACC_W.
  - 7 RDCLR: response = acc[sel], then acc[sel]=0.
  - 8 STATUS: response = {16'(LANES), 8'(NUM_ACC), 7'0, pipe_busy}.
  - Others: no side effect.
- MAC pipe, accepted at cycle T:
  - T+1: stage-1 register holds LANES products, (signed in_i + offset) * signed f_i, each 18-bit signed.
  - T+2: stage-2 register holds the adder-tree sum, width 18+log2(LANES).
  - T+3: acc[sel] updated.
  - Buffer or offset writes accepted at T+1 or later do not affect that MAC.
- Back-to-back MACs to the same acc accumulate correctly; at most 2 MACs in flight.
- Accumulate arithmetic: sign-extend the sum to ACC_W+1, add. SAT=1 clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SAT=0 keeps the low ACC_W bits.
- cmd_valid while cmd_ready=0 is ignored; the master holds the command.

Decomposition:
- Shared package cfu_pkg: op-code localparams (OP_CLEAR..OP_STATUS), FSM state enum, a product-width function, and a clog2 helper.
- One sub-module, cfu_dot_stage: LANES multipliers plus registered adder tree (stages 1-2), with in_valid/out_valid. The top holds the FSM, buffers, accumulator bank and saturation.

Test Plan:
- Reset then STATUS (defaults) -> response 0x00100401 while pipe busy, else 0x00100400; READ sel 0..3 -> 0.
- LOAD words 0-3 with inputs 0x01010101, filters 0x02020202; MAC sel0; READ sel0 -> 4128 (16*129*2); DRAIN visible when READ is issued right after the MAC response.
- SETOFF -128 (0x180), all inputs 0x80 -> MAC -> acc += 256*16*filter; with filters 0x01 READ -> 0xFFFFF000 (-4096); SETOFF 128 with same data -> +0.
- Two MACs to sel1, then LOAD of new data before the second lands -> sel1 = 2*4128 = 8256; sel0 unchanged.
- ADD sel2 0x7FFFFFF0, MAC 4128 data -> SAT=0: READ 0x80001010; SAT=1: READ 0x7FFFFFFF. RDCLR returns the value, then READ -> 0.
- reset_n pulsed low mid-MAC (cycle T+1) -> acc unchanged at 0, rsp_valid=0, cmd_ready=1 after release.
